// File: rtl/fixed_point_inverse_mac_if.sv
// Operand/result bundle for the fixed-point inverse MAC solver.
// Master side drives the request; slave side (the solver) returns the result and flags.
interface fixed_point_inverse_mac_if #(
    parameter int Word_Length = 6
);
    logic                   start;
    logic [Word_Length-1:0] D;
    logic [Word_Length-1:0] B;
    logic [Word_Length-1:0] C;
    logic                   ready;
    logic                   done;
    logic [Word_Length-1:0] Q;
    logic                   overflow;
    logic                   div_by_zero;

    modport master (
        output start, D, B, C,
        input  ready, done, Q, overflow, div_by_zero
    );

    modport slave (
        input  start, D, B, C,
        output ready, done, Q, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_point_inverse_mac.sv
// Solves Q = (D - C) / B in signed fixed point with a radix-2 restoring divider.
// Latency: done N_ITER cycles after the accepting edge (1 cycle for B=0); start is only taken while ready.
module fixed_point_inverse_mac #(
    parameter int Word_Length     = 6,
    parameter int Integer_Part    = 3,
    parameter int Fractional_Part = Word_Length - Integer_Part
) (
    input logic                      clk,
    input logic                      reset,
    fixed_point_inverse_mac_if.slave bus
);
    localparam int N_ITER = Word_Length + Fractional_Part + 1;
    localparam int CW     = $clog2(N_ITER + 1);
    localparam int QW     = Integer_Part + Fractional_Part;

    localparam logic [N_ITER-1:0]      HALF    = {{(N_ITER-1){1'b0}}, 1'b1} << (QW - 1);
    localparam logic [Word_Length-1:0] MAX_POS = {1'b0, {(Word_Length-1){1'b1}}};
    localparam logic [Word_Length-1:0] MIN_NEG = {1'b1, {(Word_Length-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [N_ITER-1:0]      dvd;
    logic [Word_Length:0]   rem;
    logic [Word_Length-1:0] bmag;
    logic                   sign_q, n_neg, b_zero;
    logic [Word_Length-1:0] q_reg;
    logic                   ovf_reg, dbz_reg;

    logic [Word_Length:0]   n_full, n_mag;
    logic [Word_Length-1:0] b_mag;
    logic [Word_Length+1:0] rem_sh, diff;
    logic                   q_bit, finish;
    logic [Word_Length:0]   rem_nxt;
    logic [N_ITER-1:0]      dvd_nxt;
    logic [Word_Length-1:0] res_q;
    logic                   res_ovf;

    // D - C in one extra bit so the difference never wraps.
    assign n_full = {bus.D[Word_Length-1], bus.D} - {bus.C[Word_Length-1], bus.C};
    assign n_mag  = n_full[Word_Length] ? -n_full : n_full;
    assign b_mag  = bus.B[Word_Length-1] ? -bus.B : bus.B;

    // Dividend shifts out MSB-first while quotient bits fill in from the LSB.
    assign rem_sh  = {rem, dvd[N_ITER-1]};
    assign diff    = rem_sh - {2'b00, bmag};
    assign q_bit   = ~diff[Word_Length+1];
    assign rem_nxt = q_bit ? diff[Word_Length:0] : rem_sh[Word_Length:0];
    assign dvd_nxt = {dvd[N_ITER-2:0], q_bit};
    assign finish  = b_zero || (cnt == CW'(N_ITER - 1));

    always_comb begin
        res_q   = '0;
        res_ovf = 1'b0;
        if (b_zero) begin
            res_q = n_neg ? MIN_NEG : MAX_POS;
        end else if (!sign_q && dvd_nxt > HALF - 1'b1) begin
            res_q   = MAX_POS;
            res_ovf = 1'b1;
        end else if (sign_q && dvd_nxt > HALF) begin
            res_q   = MIN_NEG;
            res_ovf = 1'b1;
        end else if (sign_q) begin
            res_q = -dvd_nxt[Word_Length-1:0];
        end else begin
            res_q = dvd_nxt[Word_Length-1:0];
        end
    end

    // A zero divisor still spends one DIVIDE cycle so its result lands like any other.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DIVIDE;
            DIVIDE:  if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dvd     <= '0;
            rem     <= '0;
            bmag    <= '0;
            sign_q  <= 1'b0;
            n_neg   <= 1'b0;
            b_zero  <= 1'b0;
            q_reg   <= '0;
            ovf_reg <= 1'b0;
            dbz_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd    <= {n_mag, {Fractional_Part{1'b0}}};
                        bmag   <= b_mag;
                        sign_q <= n_full[Word_Length] ^ bus.B[Word_Length-1];
                        n_neg  <= n_full[Word_Length];
                        b_zero <= (bus.B == '0);
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                DIVIDE: begin
                    if (!b_zero) begin
                        rem <= rem_nxt;
                        dvd <= dvd_nxt;
                        cnt <= cnt + 1'b1;
                    end
                    if (finish) begin
                        q_reg   <= res_q;
                        ovf_reg <= res_ovf;
                        dbz_reg <= b_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready       = (state == IDLE);
    assign bus.done        = (state == DONE);
    assign bus.Q           = q_reg;
    assign bus.overflow    = ovf_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule
